frac_div_ctrl: RTL

FRAC_DIV_CTRL -- requirements
Module: frac_div_ctrl

---
 rtl/frac_div_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/frac_div_ctrl.sv
// Fractional-N divider control: counts integer + modulator-offset periods, saturating the
// ratio to [N_MIN, 2^NW-1] and strobing the modulator once per divided period.
module frac_div_ctrl #(
    parameter int unsigned NW    = 8,
    parameter int unsigned YW    = 4,
    parameter int unsigned N_MIN = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en_i,
    input  logic [NW-1:0] n_int_i,
    input  logic [YW-1:0] sdm_y_i,
    input  logic          clamp_clr_i,
    output logic          div_o,
    output logic          sdm_step_o,
    output logic [NW-1:0] ratio_o,
    output logic          clamp_o,
    output logic [15:0]   div_cnt_o
);

    localparam int unsigned SW = NW + 2;
    localparam logic signed [SW-1:0] MinRatio = SW'(N_MIN);
    localparam logic signed [SW-1:0] MaxRatio = {2'b00, {NW{1'b1}}};

    logic [NW-1:0] cnt_q, cnt_d;
    logic [NW-1:0] ratio_q, ratio_d;
    logic          div_q, div_d;
    logic          step_q, step_d;
    logic          clamp_q, clamp_d;
    logic [15:0]   div_cnt_q, div_cnt_d;

    logic                 terminal;
    logic signed [SW-1:0] nxt;
    logic signed [SW-1:0] nxt_sat;
    logic                 sat_hit;

    assign terminal = en_i && (cnt_q == '0);

    // Unsigned integer word plus sign-extended modulator offset, with headroom for both extremes.
    assign nxt = $signed({2'b00, n_int_i}) + $signed({{(SW-YW){sdm_y_i[YW-1]}}, sdm_y_i});

    always_comb begin
        nxt_sat = nxt;
        sat_hit = 1'b0;
        if (nxt < MinRatio) begin
            nxt_sat = MinRatio;
            sat_hit = terminal;
        end else if (nxt > MaxRatio) begin
            nxt_sat = MaxRatio;
            sat_hit = terminal;
        end
    end

    always_comb begin
        cnt_d     = cnt_q;
        ratio_d   = ratio_q;
        div_d     = 1'b0;
        step_d    = 1'b0;
        div_cnt_d = div_cnt_q;
        if (terminal) begin
            ratio_d   = nxt_sat[NW-1:0];
            cnt_d     = nxt_sat[NW-1:0] - NW'(1);
            div_d     = 1'b1;
            step_d    = 1'b1;
            div_cnt_d = div_cnt_q + 16'd1;
        end else if (en_i) begin
            cnt_d = cnt_q - NW'(1);
        end
    end

    // A saturation on the same edge as a clear request wins.
    always_comb begin
        clamp_d = clamp_q;
        if (sat_hit) begin
            clamp_d = 1'b1;
        end else if (clamp_clr_i) begin
            clamp_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            ratio_q   <= '0;
            div_q     <= 1'b0;
            step_q    <= 1'b0;
            clamp_q   <= 1'b0;
            div_cnt_q <= '0;
        end else begin
            cnt_q     <= cnt_d;
            ratio_q   <= ratio_d;
            div_q     <= div_d;
            step_q    <= step_d;
            clamp_q   <= clamp_d;
            div_cnt_q <= div_cnt_d;
        end
    end

    assign div_o      = div_q;
    assign sdm_step_o = step_q;
    assign ratio_o    = ratio_q;
    assign clamp_o    = clamp_q;
    assign div_cnt_o  = div_cnt_q;

endmodule
